// File: rtl/branch_predictor.sv
// branch_predictor: 2-bit saturating-counter BHT with PC tags plus BTB, combinational lookup, decode-time training.
module branch_predictor #(
    parameter int ENTRIES = 16,
    parameter int PC_W    = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [PC_W-1:0]            PC_curr,
    output logic                       predicted_taken,
    output logic [PC_W-1:0]            predicted_target,
    output logic                       hit,
    input  logic                       update_en,
    input  logic [PC_W-1:0]            IF_ID_PC_curr,
    input  logic                       actual_taken,
    input  logic [PC_W-1:0]            actual_target,
    input  logic [$clog2(ENTRIES)-1:0] dbg_idx,
    output logic [PC_W-1:0]            dbg_bht,
    output logic [PC_W-1:0]            dbg_btb,
    output logic [PC_W-1:0]            dbg_tag
);
    localparam int IW = $clog2(ENTRIES);

    logic [ENTRIES-1:0] valid;
    logic [PC_W-1:0]    tag    [ENTRIES];
    logic [1:0]         cnt    [ENTRIES];
    logic [PC_W-1:0]    target [ENTRIES];
    logic [IW-1:0]      li, ui;
    logic               uhit;

    // Instructions are 2 bytes, so PC[0] is skipped for indexing but kept in the tag.
    assign li = PC_curr[IW:1];
    assign ui = IF_ID_PC_curr[IW:1];
    assign uhit = valid[ui] && tag[ui] == IF_ID_PC_curr;

    always_comb begin
        hit              = valid[li] && tag[li] == PC_curr;
        predicted_taken  = hit && cnt[li][1];
        predicted_target = predicted_taken ? target[li] : PC_curr + PC_W'(2);
        dbg_bht          = {valid[dbg_idx], (PC_W-3)'(0), cnt[dbg_idx]};
        dbg_btb          = target[dbg_idx];
        dbg_tag          = tag[dbg_idx];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= '0;
            for (int k = 0; k < ENTRIES; k++) begin
                tag[k]    <= '0;
                cnt[k]    <= 2'b00;
                target[k] <= '0;
            end
        end else if (update_en) begin
            if (uhit) begin
                cnt[ui] <= actual_taken ? (cnt[ui] == 2'b11 ? 2'b11 : cnt[ui] + 2'd1)
                                        : (cnt[ui] == 2'b00 ? 2'b00 : cnt[ui] - 2'd1);
            end else begin
                valid[ui] <= 1'b1;
                tag[ui]   <= IF_ID_PC_curr;
                cnt[ui]   <= actual_taken ? 2'b10 : 2'b01;
            end
            if (actual_taken)
                target[ui] <= actual_target;
        end
    end
endmodule

// File: tb/tb_branch_predictor.sv
// tb_branch_predictor: directed vector table, hand sequences and randomized traffic against a behavioural model.
module tb_branch_predictor;
    logic        clk = 0;
    logic        rst;
    logic [15:0] PC_curr;
    logic        predicted_taken;
    logic [15:0] predicted_target;
    logic        hit;
    logic        update_en;
    logic [15:0] IF_ID_PC_curr;
    logic        actual_taken;
    logic [15:0] actual_target;
    logic [3:0]  dbg_idx;
    logic [15:0] dbg_bht, dbg_btb, dbg_tag;

    int total = 0;
    int bad   = 0;

    branch_predictor dut (
        .clk(clk), .rst(rst), .PC_curr(PC_curr),
        .predicted_taken(predicted_taken), .predicted_target(predicted_target), .hit(hit),
        .update_en(update_en), .IF_ID_PC_curr(IF_ID_PC_curr),
        .actual_taken(actual_taken), .actual_target(actual_target),
        .dbg_idx(dbg_idx), .dbg_bht(dbg_bht), .dbg_btb(dbg_btb), .dbg_tag(dbg_tag)
    );

    always #5 clk = ~clk;

    // Reference model: plain integers, index = (pc / 2) mod 16.
    bit          m_v   [16];
    int          m_c   [16];
    logic [15:0] m_tag [16];
    logic [15:0] m_tgt [16];

    function automatic void m_reset();
        for (int k = 0; k < 16; k++) begin
            m_v[k] = 0; m_c[k] = 0; m_tag[k] = 0; m_tgt[k] = 0;
        end
    endfunction

    function automatic void m_update(input logic [15:0] pc, input bit tk, input logic [15:0] tg);
        int i = (int'(pc) / 2) % 16;
        if (m_v[i] && m_tag[i] == pc) begin
            m_c[i] = tk ? m_c[i] + 1 : m_c[i] - 1;
            if (m_c[i] > 3) m_c[i] = 3;
            if (m_c[i] < 0) m_c[i] = 0;
        end else begin
            m_v[i] = 1; m_tag[i] = pc; m_c[i] = tk ? 2 : 1;
        end
        if (tk) m_tgt[i] = tg;
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic chk_model(input string tagname);
        int i = (int'(PC_curr) / 2) % 16;
        bit h = m_v[i] && m_tag[i] == PC_curr;
        bit p = h && m_c[i] >= 2;
        logic [15:0] nxt = PC_curr + 16'd2;
        chk({tagname, ".hit"}, 16'(hit), 16'(h));
        chk({tagname, ".ptaken"}, 16'(predicted_taken), 16'(p));
        chk({tagname, ".ptarget"}, predicted_target, p ? m_tgt[i] : nxt);
    endtask

    task automatic chk_dbg(input string tagname);
        int i = int'(dbg_idx);
        chk({tagname, ".bht"}, dbg_bht, {m_v[i], 13'b0, 2'(m_c[i])});
        chk({tagname, ".btb"}, dbg_btb, m_tgt[i]);
        chk({tagname, ".tag"}, dbg_tag, m_tag[i]);
    endtask

    typedef struct {
        logic        upd;
        logic [15:0] upc;
        logic        tk;
        logic [15:0] tg;
        logic [15:0] look;
        logic [3:0]  idx;
        logic        eh, ep;
        logic [15:0] et, eb, ebt, etag;
    } vec_t;

    vec_t vecs[11];

    initial begin
        vecs[0]  = '{1, 16'h0024, 1, 16'h0040, 16'h0024, 2, 1, 1, 16'h0040, 16'h8002, 16'h0040, 16'h0024};
        vecs[1]  = '{1, 16'h0024, 1, 16'h0040, 16'h0024, 2, 1, 1, 16'h0040, 16'h8003, 16'h0040, 16'h0024};
        vecs[2]  = '{1, 16'h0024, 1, 16'h0040, 16'h0024, 2, 1, 1, 16'h0040, 16'h8003, 16'h0040, 16'h0024};
        vecs[3]  = '{1, 16'h0044, 0, 16'h1234, 16'h0024, 2, 0, 0, 16'h0026, 16'h8001, 16'h0040, 16'h0044};
        vecs[4]  = '{1, 16'h0044, 1, 16'h0050, 16'h0044, 2, 1, 1, 16'h0050, 16'h8002, 16'h0050, 16'h0044};
        vecs[5]  = '{1, 16'h0044, 1, 16'h0050, 16'h0044, 2, 1, 1, 16'h0050, 16'h8003, 16'h0050, 16'h0044};
        vecs[6]  = '{1, 16'h0044, 0, 16'h9999, 16'h0044, 2, 1, 1, 16'h0050, 16'h8002, 16'h0050, 16'h0044};
        vecs[7]  = '{1, 16'h0044, 0, 16'h9999, 16'h0044, 2, 1, 0, 16'h0046, 16'h8001, 16'h0050, 16'h0044};
        vecs[8]  = '{1, 16'h0044, 0, 16'h9999, 16'h0044, 2, 1, 0, 16'h0046, 16'h8000, 16'h0050, 16'h0044};
        vecs[9]  = '{1, 16'h0044, 0, 16'h9999, 16'h0044, 2, 1, 0, 16'h0046, 16'h8000, 16'h0050, 16'h0044};
        vecs[10] = '{0, 16'h0000, 0, 16'h0000, 16'hFFFE, 15, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000};

        rst = 1; update_en = 0; PC_curr = 16'h0010; IF_ID_PC_curr = 0;
        actual_taken = 0; actual_target = 0; dbg_idx = 0;
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst.hit", 16'(hit), 0);
        chk("rst.ptaken", 16'(predicted_taken), 0);
        chk("rst.ptarget", predicted_target, 16'h0012);
        for (int k = 0; k < 16; k++) begin
            dbg_idx = 4'(k);
            #1;
            chk($sformatf("rst.bht%0d", k), dbg_bht, 16'h0000);
            chk($sformatf("rst.btb%0d", k), dbg_btb, 16'h0000);
            chk($sformatf("rst.tag%0d", k), dbg_tag, 16'h0000);
        end
        rst = 0;

        foreach (vecs[n]) begin
            update_en = vecs[n].upd; IF_ID_PC_curr = vecs[n].upc;
            actual_taken = vecs[n].tk; actual_target = vecs[n].tg;
            PC_curr = vecs[n].look; dbg_idx = vecs[n].idx;
            @(posedge clk);
            if (vecs[n].upd) m_update(vecs[n].upc, vecs[n].tk, vecs[n].tg);
            #1 update_en = 0;
            #1;
            chk($sformatf("vec%0d.hit", n), 16'(hit), 16'(vecs[n].eh));
            chk($sformatf("vec%0d.ptaken", n), 16'(predicted_taken), 16'(vecs[n].ep));
            chk($sformatf("vec%0d.ptarget", n), predicted_target, vecs[n].et);
            chk($sformatf("vec%0d.bht", n), dbg_bht, vecs[n].eb);
            chk($sformatf("vec%0d.btb", n), dbg_btb, vecs[n].ebt);
            chk($sformatf("vec%0d.tag", n), dbg_tag, vecs[n].etag);
        end

        // Same-cycle lookup and update: lookup sees the pre-update counter.
        update_en = 1; IF_ID_PC_curr = 16'h0006; actual_taken = 0; actual_target = 16'h0100;
        @(posedge clk);
        m_update(16'h0006, 0, 16'h0100);
        #1;
        PC_curr = 16'h0006; actual_taken = 1; dbg_idx = 3;
        #1;
        chk("same.bht_before", dbg_bht, 16'h8001);
        chk("same.ptaken_before", 16'(predicted_taken), 0);
        chk("same.ptarget_before", predicted_target, 16'h0008);
        @(posedge clk);
        m_update(16'h0006, 1, 16'h0100);
        #1 update_en = 0;
        #1;
        chk("same.ptaken_after", 16'(predicted_taken), 1);
        chk("same.ptarget_after", predicted_target, 16'h0100);
        chk("same.bht_after", dbg_bht, 16'h8002);

        // Randomized traffic over a small PC pool so entries alias and hit often.
        for (int c = 0; c < 400; c++) begin
            logic [15:0] upc, lpc;
            upc = 16'(($urandom_range(0, 63) << 1) | ($urandom_range(0, 9) == 0 ? 1 : 0));
            lpc = ($urandom_range(0, 15) == 0) ? 16'hFFFE :
                  16'(($urandom_range(0, 63) << 1) | ($urandom_range(0, 9) == 0 ? 1 : 0));
            rst = ($urandom_range(0, 59) == 0);
            update_en = $urandom_range(0, 2) != 0;
            IF_ID_PC_curr = upc; actual_taken = 1'($urandom_range(0, 1));
            actual_target = 16'($urandom); PC_curr = lpc; dbg_idx = 4'($urandom_range(0, 15));
            #1;
            chk_model("rnd.pre");
            @(posedge clk);
            if (rst) m_reset();
            else if (update_en) m_update(upc, actual_taken, actual_target);
            #1;
            chk_model("rnd.post");
            chk_dbg("rnd.dbg");
        end
        rst = 0; update_en = 0;

        // Reset and update on the same edge: reset wins.
        @(negedge clk);
        rst = 1; update_en = 1; IF_ID_PC_curr = 16'h0006; actual_taken = 1; actual_target = 16'h0200;
        PC_curr = 16'h0006;
        @(posedge clk);
        m_reset();
        #1 rst = 0; update_en = 0;
        #1;
        chk("coll.hit", 16'(hit), 0);
        chk("coll.ptarget", predicted_target, 16'h0008);
        for (int k = 0; k < 16; k++) begin
            dbg_idx = 4'(k);
            #1;
            chk($sformatf("coll.bht%0d", k), dbg_bht, 16'h0000);
            chk($sformatf("coll.btb%0d", k), dbg_btb, 16'h0000);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
